divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/div_pkg.sv | 13 +
 rtl/sub_cla.sv | 86 ++++++++
 rtl/divider.sv | 128 ++++++++++++
 tb/tb_divider.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int ITER      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_cla.sv
// Combinational a - b as a + ~b + 1 with 4-bit carry-lookahead groups.
module sub_cla #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    localparam int NG = (W + 3) / 4;

    logic [W-1:0]  w_g;
    logic [W-1:0]  w_p;
    logic [NG-1:0] w_gg;
    logic [NG-1:0] w_gp;
    logic [NG:0]   w_gc;

    assign w_g = a & ~b;
    assign w_p = a ^ ~b;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            localparam int LO = 4 * gi;
            localparam int GW = ((W - LO) < 4) ? (W - LO) : 4;

            logic          w_ggl;
            logic          w_gpl;
            logic [GW-1:0] w_c;

            always_comb begin : p_grp_gp
                logic gg;
                logic pp;
                gg = 1'b0;
                pp = 1'b1;
                for (int m = GW - 1; m >= 0; m--) begin
                    gg = gg | (pp & w_g[LO+m]);
                    pp = pp & w_p[LO+m];
                end
                w_ggl = gg;
                w_gpl = pp;
            end

            // Bit carries inside the group look ahead from the group carry-in.
            always_comb begin : p_grp_c
                logic t;
                logic pp;
                w_c    = '0;
                w_c[0] = w_gc[gi];
                for (int k = 1; k < GW; k++) begin
                    t  = 1'b0;
                    pp = 1'b1;
                    for (int m = k - 1; m >= 0; m--) begin
                        t  = t | (pp & w_g[LO+m]);
                        pp = pp & w_p[LO+m];
                    end
                    w_c[k] = t | (pp & w_gc[gi]);
                end
            end

            assign w_gg[gi]       = w_ggl;
            assign w_gp[gi]       = w_gpl;
            assign diff[LO +: GW] = w_p[LO +: GW] ^ w_c;
        end
    endgenerate

    // Second level: group carries from group generate/propagate, carry-in = 1.
    always_comb begin : p_grp_carry
        logic t;
        logic pp;
        w_gc = '0;
        for (int j = 0; j <= NG; j++) begin
            t  = 1'b0;
            pp = 1'b1;
            for (int m = j - 1; m >= 0; m--) begin
                t  = t | (pp & w_gg[m]);
                pp = pp & w_gp[m];
            end
            w_gc[j] = t | pp;
        end
    end

    assign borrow = ~w_gc[NG];

endmodule

// File: rtl/divider.sv
// Iterative restoring unsigned divider: one quotient bit per RUN cycle,
// valid/ready handshakes on both sides, registered result outputs.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_q;
    logic [WIDTH:0]   r_r;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;

    logic [CW-1:0]    w_idx;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic             w_qbit;
    logic [WIDTH:0]   w_r_next;
    logic [WIDTH-1:0] w_q_next;

    // Dividend bits are picked MSB first by the counter; the latched operand never moves.
    assign w_idx    = CW'(WIDTH - 1) - r_cnt;
    assign w_shift  = {r_r[WIDTH-1:0], r_a[w_idx]};
    // A set top bit would mean the shifted value already exceeds any divisor.
    assign w_qbit   = ~w_borrow | r_r[WIDTH];
    assign w_r_next = w_qbit ? w_diff : w_shift;
    assign w_q_next = {r_q, w_qbit};

    sub_cla #(
        .W (WIDTH + 1)
    ) u_sub (
        .a      (w_shift),
        .b      ({1'b0, r_b}),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dz        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= dividend;
                        r_b        <= divisor;
                        r_q        <= '0;
                        r_r        <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        if (divisor == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_quot      <= '1;
                            r_rem       <= dividend;
                            r_dz        <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_dz    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r_q   <= w_q_next[WIDTH-2:0];
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(ITER - 1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_quot      <= w_q_next;
                        r_rem       <= w_r_next[WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign div_zero  = r_dz;

endmodule

// File: tb/tb_divider.sv
// Directed + random bench for divider: scoreboard of reference results,
// latency, hold-under-backpressure and reset-abort checks.
module tb_divider;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk_result(input string tag, input exp_t e);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " quotient"}, 32'(quotient), 32'(e.q));
        chk({tag, " remainder"}, 32'(remainder), 32'(e.r));
        chk({tag, " div_zero"}, 32'(div_zero), 32'(e.dz));
    endtask

    // Cycle 0 is the cycle in_valid is presented; the result is checked at the
    // first cycle out_valid is seen (1 for zero divisor, 17 otherwise).
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall, input bit scramble);
        exp_t e;
        int   cyc;
        @(negedge clk);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        in_valid = scramble;
        while (!out_valid && cyc < 40) begin
            if (scramble) begin
                dividend = 16'($urandom);
                divisor  = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, 32'(cyc), (b == '0) ? 32'd1 : 32'd17);
        e = sb.pop_front();
        if (!out_valid) return;
        for (int i = 0; i < stall; i++) begin
            chk_result({tag, " stall"}, e);
            @(negedge clk);
        end
        chk_result(tag, e);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " idle quotient hold"}, 32'(quotient), 32'(e.q));
        chk({tag, " idle remainder hold"}, 32'(remainder), 32'(e.r));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset div_zero", 32'(div_zero), 32'd0);
        rst_n = 1'b1;

        run_op("100/7", 16'd100, 16'd7, 0, 1'b0);
        run_op("FFFF/1", 16'hFFFF, 16'd1, 0, 1'b0);
        run_op("3/10", 16'd3, 16'd10, 0, 1'b0);
        run_op("5/0", 16'd5, 16'd0, 0, 1'b0);
        run_op("40000/200", 16'd40000, 16'd200, 5, 1'b0);

        // Abort an operation at RUN iteration 8 with an asynchronous reset.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd100;
        divisor  = 16'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort quotient", 32'(quotient), 32'd0);
        chk("abort remainder", 32'(remainder), 32'd0);
        chk("abort div_zero", 32'(div_zero), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort held out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort no result", 32'(out_valid), 32'd0);
        run_op("9/3", 16'd9, 16'd3, 0, 1'b0);

        run_op("1234/56 scramble", 16'd1234, 16'd56, 1, 1'b1);
        run_op("7/0 scramble", 16'd7, 16'd0, 0, 1'b1);

        for (int n = 0; n < 2000; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 15))
                0:       rb = '0;
                1, 2, 3: rb = 16'($urandom_range(1, 15));
                4:       rb = ra;
                default: rb = 16'($urandom);
            endcase
            run_op("rnd", ra, rb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
